data_memory_arbiter: RTL and testbench

//  Shares the single port of data_memory between two requesters: m0 (core data port) and m1 (loader/debug port).

---
 rtl/data_memory_arbiter_if.sv | 14 +
 rtl/data_memory_arbiter.sv | 128 ++++++++++++
 tb/tb_data_memory_arbiter.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_arbiter_if.sv
// One requester port of the data memory arbiter: a held request with payload,
// answered by a single-cycle ack carrying error flag and read data.
interface data_memory_arbiter_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic        err;
    logic [31:0] rdata;

    modport master (output req, we, addr, wdata, input ack, err, rdata);
    modport slave  (input req, we, addr, wdata, output ack, err, rdata);
endinterface

// File: rtl/data_memory_arbiter.sv
// Shares the single data_memory port between m0 (core) and m1 (loader/debug).
// Each transaction runs IDLE -> ACCESS -> RESP with a burst-limited sticky grant.
module data_memory_arbiter #(
    parameter int DEPTH     = 64,
    parameter int MAX_BURST = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    data_memory_arbiter_if.slave   m0,
    data_memory_arbiter_if.slave   m1,
    output logic                   mem_we,
    output logic [31:0]            mem_addr,
    output logic [31:0]            mem_wdata,
    input  logic [31:0]            mem_rdata
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t           state_q, state_d;
    logic             sel_q, sel_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;
    logic             last_grant_q, last_grant_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

    logic             in_range;
    logic             winner;
    logic             ack0;
    logic             ack1;

    assign in_range = (addr_q[31:2] < 30'(DEPTH));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            sel_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            last_grant_q <= 1'b0;
            burst_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            last_grant_q <= last_grant_d;
            burst_cnt_q  <= burst_cnt_d;
        end
    end

    // The previous winner keeps the port under contention until it has used up its burst.
    always_comb begin
        if (m0.req && m1.req) begin
            winner = (burst_cnt_q < CNT_W'(MAX_BURST)) ? last_grant_q : ~last_grant_q;
        end else begin
            winner = m1.req;
        end
    end

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        last_grant_d = last_grant_q;
        burst_cnt_d  = burst_cnt_q;
        case (state_q)
            IDLE: begin
                if (m0.req || m1.req) begin
                    state_d = ACCESS;
                    sel_d   = winner;
                    we_d    = winner ? m1.we    : m0.we;
                    addr_d  = winner ? m1.addr  : m0.addr;
                    wdata_d = winner ? m1.wdata : m0.wdata;
                    if (winner == last_grant_q) begin
                        if (burst_cnt_q < CNT_W'(MAX_BURST)) begin
                            burst_cnt_d = burst_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        burst_cnt_d  = CNT_W'(1);
                        last_grant_d = winner;
                    end
                end
            end
            ACCESS: begin
                rdata_d = (in_range && !we_q) ? mem_rdata : '0;
                err_d   = ~in_range;
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Out-of-range writes never reach the memory; the address bus simply holds between accesses.
    always_comb begin
        mem_we    = (state_q == ACCESS) && we_q && in_range;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        ack0      = (state_q == RESP) && !sel_q;
        ack1      = (state_q == RESP) && sel_q;
        m0.ack    = ack0;
        m0.err    = ack0 && err_q;
        m0.rdata  = ack0 ? rdata_q : '0;
        m1.ack    = ack1;
        m1.err    = ack1 && err_q;
        m1.rdata  = ack1 ? rdata_q : '0;
    end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed and randomized bench for data_memory_arbiter against a transaction-level
// model of the grant policy and a shadow copy of the memory contents.
module tb_data_memory_arbiter;

    localparam int DEPTH     = 64;
    localparam int MAX_BURST = 4;

    logic        clk;
    logic        reset_n;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        preload;

    logic [31:0] seed_mem [0:63];
    logic [31:0] mem_array [0:63];
    logic [31:0] ref_mem [0:63];

    int checks   = 0;
    int failures = 0;
    int m_last;
    int m_burst;
    int grants[$];
    logic [31:0] last_rdata;

    data_memory_arbiter_if m0_if ();
    data_memory_arbiter_if m1_if ();

    data_memory_arbiter #(.DEPTH(DEPTH), .MAX_BURST(MAX_BURST)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .m0        (m0_if.slave),
        .m1        (m1_if.slave),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for data_memory: combinational read, write on the clock edge.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) mem_array[i] <= seed_mem[i];
        end else if (mem_we) begin
            mem_array[mem_addr[7:2]] <= mem_wdata;
        end
    end
    assign mem_rdata = mem_array[mem_addr[7:2]];

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_master(input int m, input logic req, input logic we,
                              input logic [31:0] addr, input logic [31:0] wdata);
        if (m == 0) begin
            m0_if.req = req; m0_if.we = we; m0_if.addr = addr; m0_if.wdata = wdata;
        end else begin
            m1_if.req = req; m1_if.we = we; m1_if.addr = addr; m1_if.wdata = wdata;
        end
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 4) == 0) return 32'($urandom_range(DEPTH, 2 * DEPTH - 1) * 4);
        return 32'($urandom_range(0, DEPTH - 1) * 4);
    endfunction

    task automatic apply_stimulus(input int m);
        set_master(m, 1'b1, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
    endtask

    // Grant policy expressed as a sticky owner with a bounded run under contention.
    function automatic int pick_winner(input bit r0, input bit r1);
        int w;
        if (r0 && !r1) w = 0;
        else if (r1 && !r0) w = 1;
        else w = (m_burst < MAX_BURST) ? m_last : 1 - m_last;
        if (w == m_last) m_burst = (m_burst + 1 > MAX_BURST) ? MAX_BURST : m_burst + 1;
        else begin
            m_burst = 1;
            m_last  = w;
        end
        return w;
    endfunction

    task automatic check_outputs_zero(input string tag);
        check_output({tag, "_ack0"},   32'(m0_if.ack), 32'd0);
        check_output({tag, "_ack1"},   32'(m1_if.ack), 32'd0);
        check_output({tag, "_mem_we"}, 32'(mem_we),    32'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        apply_stimulus(0);
        apply_stimulus(1);
        #2;
        check_outputs_zero("rst");
        check_output("rst_err0",   32'(m0_if.err), 32'd0);
        check_output("rst_err1",   32'(m1_if.err), 32'd0);
        check_output("rst_rdata0", m0_if.rdata,    32'd0);
        check_output("rst_rdata1", m1_if.rdata,    32'd0);
        check_output("rst_addr",   mem_addr,       32'd0);
        check_output("rst_wdata",  mem_wdata,      32'd0);
        @(posedge clk);
        @(negedge clk);
        set_master(0, 1'b0, 1'b0, 32'd0, 32'd0);
        set_master(1, 1'b0, 1'b0, 32'd0, 32'd0);
        reset_n = 1'b1;
        m_last  = 0;
        m_burst = 0;
        @(posedge clk);
        #1;
        check_outputs_zero("post_rst");
    endtask

    // Entered and left one time unit after the rising edge that lands in IDLE.
    task automatic run_txn(input bit renew);
        bit          r0;
        bit          r1;
        int          w;
        int          seen;
        logic        twe;
        logic [31:0] ta;
        logic [31:0] td;
        logic        inr;
        logic [31:0] exp_rd;
        r0 = m0_if.req;
        r1 = m1_if.req;
        if (!r0 && !r1) begin
            @(posedge clk);
            #1;
            check_outputs_zero("idle");
            return;
        end
        w   = pick_winner(r0, r1);
        twe = (w == 0) ? m0_if.we    : m1_if.we;
        ta  = (w == 0) ? m0_if.addr  : m1_if.addr;
        td  = (w == 0) ? m0_if.wdata : m1_if.wdata;
        inr = (ta[31:2] < 30'(DEPTH));
        @(posedge clk);
        #1;
        check_output("access_we",   32'(mem_we), 32'(twe && inr));
        check_output("access_addr", mem_addr,    ta);
        if (twe) check_output("access_wdata", mem_wdata, td);
        check_output("access_ack", 32'({m1_if.ack, m0_if.ack}), 32'd0);
        @(posedge clk);
        #1;
        exp_rd = (inr && !twe) ? ref_mem[ta[7:2]] : 32'd0;
        if (twe && inr) ref_mem[ta[7:2]] = td;
        seen = m1_if.ack ? 1 : (m0_if.ack ? 0 : -1);
        grants.push_back(seen);
        check_output("resp_we", 32'(mem_we), 32'd0);
        if (w == 0) begin
            last_rdata = m0_if.rdata;
            check_output("resp_ack0",   32'(m0_if.ack), 32'd1);
            check_output("resp_err0",   32'(m0_if.err), 32'(!inr));
            check_output("resp_rdata0", m0_if.rdata,    exp_rd);
            check_output("resp_idle1",  32'({m1_if.ack, m1_if.err}) | m1_if.rdata, 32'd0);
        end else begin
            last_rdata = m1_if.rdata;
            check_output("resp_ack1",   32'(m1_if.ack), 32'd1);
            check_output("resp_err1",   32'(m1_if.err), 32'(!inr));
            check_output("resp_rdata1", m1_if.rdata,    exp_rd);
            check_output("resp_idle0",  32'({m0_if.ack, m0_if.err}) | m0_if.rdata, 32'd0);
        end
        if (renew) apply_stimulus(w);
        else set_master(w, 1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp3 [9];
        int exp6 [5];
        exp3 = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
        exp6 = '{1, 1, 1, 1, 0};
        for (int i = 0; i < 64; i++) begin
            seed_mem[i] = $urandom;
            ref_mem[i]  = seed_mem[i];
        end
        preload = 1'b1;
        set_master(0, 1'b0, 1'b0, 32'd0, 32'd0);
        set_master(1, 1'b0, 1'b0, 32'd0, 32'd0);
        do_reset();
        preload = 1'b0;

        $display("[TB] write then read back on m0");
        set_master(0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
        run_txn(1'b0);
        set_master(0, 1'b1, 1'b0, 32'h10, 32'd0);
        run_txn(1'b0);
        check_output("t2_readback", last_rdata, 32'hDEADBEEF);

        $display("[TB] out-of-range write on m1");
        set_master(1, 1'b1, 1'b1, 32'h100, 32'h12345678);
        run_txn(1'b0);
        set_master(1, 1'b1, 1'b0, 32'hFC, 32'd0);
        run_txn(1'b0);
        check_output("t4_last_word", last_rdata, seed_mem[63]);

        $display("[TB] reset during an in-flight write");
        set_master(0, 1'b1, 1'b1, 32'h20, ~ref_mem[8]);
        @(posedge clk);
        #1;
        check_output("t5_access_we", 32'(mem_we), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check_output("t5_we_async", 32'(mem_we), 32'd0);
        do_reset();
        check_output("t5_word_kept", mem_array[8], ref_mem[8]);

        $display("[TB] continuous contention");
        grants.delete();
        apply_stimulus(0);
        apply_stimulus(1);
        for (int i = 0; i < 9; i++) run_txn(1'b1);
        for (int i = 0; i < 9; i++) check_output($sformatf("t3_grant%0d", i), 32'(grants[i]), 32'(exp3[i]));
        set_master(0, 1'b0, 1'b0, 32'd0, 32'd0);
        set_master(1, 1'b0, 1'b0, 32'd0, 32'd0);

        $display("[TB] m0 joins during an m1 burst");
        do_reset();
        grants.delete();
        apply_stimulus(1);
        run_txn(1'b1);
        run_txn(1'b1);
        apply_stimulus(0);
        for (int i = 0; i < 3; i++) run_txn(1'b1);
        for (int i = 0; i < 5; i++) check_output($sformatf("t6_grant%0d", i), 32'(grants[i]), 32'(exp6[i]));

        $display("[TB] random traffic");
        for (int i = 0; i < 40; i++) begin
            if (!m0_if.req && $urandom_range(0, 1) == 1) apply_stimulus(0);
            if (!m1_if.req && $urandom_range(0, 1) == 1) apply_stimulus(1);
            run_txn(1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 64; i++) check_output($sformatf("final_mem%0d", i), mem_array[i], ref_mem[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
